mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 65 ++++++
 rtl/mem_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: the bus bundle between two requesters (instruction fetch and
// data port), the arbiter and a shared single-port memory.
//
// Handshake: a requester raises *_req_i with its address, write enable and
// write data, and keeps all of them stable until it sees *_gnt_o high in the
// same cycle. A cycle with req && gnt is the issue cycle of that access. A read
// returns exactly one cycle later as a one-cycle *_rvalid_o pulse with *_rdata_o.
// There is no backpressure on responses.
//
// Signal names carry the arbiter's point of view (_i into the arbiter,
// _o out of it).
//   slave  : arbiter side
//   master : requester / memory side (testbench)
// The dbg_* signals expose the response-owner state and the fetch wait
// counter for observation only.
interface mem_arbiter_if #(
  parameter int AWIDTH   = 32,
  parameter int DWIDTH   = 32,
  parameter int MAX_WAIT = 4
);
  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic              i_req_i;
  logic [AWIDTH-1:0] i_addr_i;
  logic              i_gnt_o;
  logic              i_rvalid_o;
  logic [DWIDTH-1:0] i_rdata_o;

  logic              d_req_i;
  logic              d_we_i;
  logic [AWIDTH-1:0] d_addr_i;
  logic [DWIDTH-1:0] d_wdata_i;
  logic              d_gnt_o;
  logic              d_rvalid_o;
  logic [DWIDTH-1:0] d_rdata_o;

  logic [AWIDTH-1:0] mem_addr_o;
  logic [DWIDTH-1:0] mem_data_o;
  logic              mem_read_en_o;
  logic              mem_write_en_o;
  logic [DWIDTH-1:0] mem_data_i;

  logic [1:0]        dbg_resp_o;
  logic [CW-1:0]     dbg_wait_cnt_o;

  modport slave (
    input  i_req_i, i_addr_i,
    output i_gnt_o, i_rvalid_o, i_rdata_o,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o,
    input  mem_data_i,
    output dbg_resp_o, dbg_wait_cnt_o
  );

  modport master (
    output i_req_i, i_addr_i,
    input  i_gnt_o, i_rvalid_o, i_rdata_o,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o,
    output mem_data_i,
    input  dbg_resp_o, dbg_wait_cnt_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch / data) arbiter in front of a single-port
// memory with one-cycle read latency.
//
// Ports:
//   clk   - single clock, rising edge
//   reset - asynchronous, active-low reset
//   bus   - mem_arbiter_if.slave: fetch request/response, data request/
//           response, shared-memory access and debug state
//
// At most one access issues per cycle. Data normally wins a collision; a
// fetch that has been blocked MAX_WAIT cycles wins the next collision. Grants
// are combinational; the response owner is remembered for one cycle so the
// returning memory data is steered to the right port.
module mem_arbiter #(
  parameter int AWIDTH   = 32,
  parameter int DWIDTH   = 32,
  parameter int MAX_WAIT = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam int            CW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  typedef enum logic [1:0] {
    RESP_NONE  = 2'd0,
    RESP_INSTR = 2'd1,
    RESP_DATA  = 2'd2
  } resp_e;

  resp_e         resp_q, resp_d;
  logic [CW-1:0] i_wait_cnt_q, i_wait_cnt_d;
  logic          i_gnt, d_gnt;

  // Grants are gated by reset so they drop the moment reset asserts, not at
  // the next clock edge.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (reset) begin
      if (bus.i_req_i && (!bus.d_req_i || (i_wait_cnt_q == WAIT_MAX))) begin
        i_gnt = 1'b1;
      end else if (bus.d_req_i) begin
        d_gnt = 1'b1;
      end
    end
  end

  // Next state: wait counter and response owner.
  always_comb begin
    i_wait_cnt_d = '0;
    resp_d       = RESP_NONE;
    if (bus.i_req_i && !i_gnt) begin
      i_wait_cnt_d = (i_wait_cnt_q == WAIT_MAX) ? i_wait_cnt_q : i_wait_cnt_q + CW'(1);
    end
    if (i_gnt) begin
      resp_d = RESP_INSTR;
    end else if (d_gnt && !bus.d_we_i) begin
      resp_d = RESP_DATA;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_q       <= RESP_NONE;
      i_wait_cnt_q <= '0;
    end else begin
      resp_q       <= resp_d;
      i_wait_cnt_q <= i_wait_cnt_d;
    end
  end

  // Output steering: memory carries only the winner; idle cycles drive zero.
  always_comb begin
    bus.i_gnt_o        = i_gnt;
    bus.d_gnt_o        = d_gnt;
    bus.mem_addr_o     = '0;
    bus.mem_data_o     = '0;
    bus.mem_read_en_o  = 1'b0;
    bus.mem_write_en_o = 1'b0;
    if (i_gnt) begin
      bus.mem_addr_o    = bus.i_addr_i;
      bus.mem_read_en_o = 1'b1;
    end else if (d_gnt) begin
      bus.mem_addr_o = bus.d_addr_i;
      if (bus.d_we_i) begin
        bus.mem_write_en_o = 1'b1;
        bus.mem_data_o     = bus.d_wdata_i;
      end else begin
        bus.mem_read_en_o = 1'b1;
      end
    end

    bus.i_rvalid_o = (resp_q == RESP_INSTR);
    bus.d_rvalid_o = (resp_q == RESP_DATA);
    bus.i_rdata_o  = (resp_q == RESP_INSTR) ? bus.mem_data_i : '0;
    bus.d_rdata_o  = (resp_q == RESP_DATA)  ? bus.mem_data_i : '0;

    bus.dbg_resp_o     = resp_q;
    bus.dbg_wait_cnt_o = i_wait_cnt_q;
  end
endmodule
